// File: rtl/mem_responder.sv
// Word-wide memory responder with programmable wait states.
// Flags misaligned and out-of-range accesses with err alongside ready.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] Address,
  input  logic [31:0] WriteDataMem,
  output logic [31:0] MemData,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept;
  logic          commit;
  logic          invalid;
  logic [AW-1:0] idx;

  assign accept  = req &&
                   ((state_q == S_IDLE) ||
                    (state_q == S_DONE));
  assign commit  = (state_q == S_ACCESS) &&
                   (cnt_q == 4'd0);
  assign idx     = addr_q[AW+1:2];
  assign invalid = (addr_q[1:0] != 2'b00) ||
                   (|addr_q[31:AW+2]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    ready_d = commit;
    err_d   = commit && invalid;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = S_ACCESS;
          cnt_d   = WS;
          addr_d  = Address;
          wdata_d = WriteDataMem;
          wr_d    = wr;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_DONE;
          if (!wr_q) begin
            rdata_d = invalid ? '0 : mem_q[idx];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (commit && wr_q && !invalid) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign MemData = rdata_q;
  assign ready   = ready_q;
  assign err     = err_q;
  assign busy    = (state_q == S_ACCESS);

endmodule
